// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and default-slave state type for the response mux.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DEF_IDLE = 2'b00,
        DEF_ERR1 = 2'b01,
        DEF_ERR2 = 2'b10
    } def_state_t;

    // NONSEQ and SEQ both have bit 1 set; IDLE/BUSY never demand a response.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped/illegal transfers with the two-cycle AHB ERROR.
// Latency: ERROR starts in the data phase following the accepting address phase.
// Backpressure: ERR1 drives HREADY low for one cycle; ERR2 completes it.
// Ports: HCLK, HRESETn; HREADY (muxed bus ready), err_req (address phase needs
//        an ERROR); def_hready/def_hresp/def_active (registered), err_cnt.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HREADY,
    input  logic             err_req,
    output logic             def_hready,
    output logic             def_hresp,
    output logic             def_active,
    output logic [CNT_W-1:0] err_cnt
);

    def_state_t state_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= DEF_IDLE;
            def_hready <= 1'b1;
            def_hresp  <= HRESP_OKAY;
            def_active <= 1'b0;
            err_cnt    <= '0;
        end else begin
            case (state_q)
                DEF_ERR1: begin
                    // Second ERROR cycle follows unconditionally.
                    state_q    <= DEF_ERR2;
                    def_hready <= 1'b1;
                    def_hresp  <= HRESP_ERROR;
                    def_active <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
                default: begin
                    // DEF_IDLE and DEF_ERR2 both sit on an address phase;
                    // only an accepted one may start a new ERROR.
                    if (HREADY) begin
                        if (err_req) begin
                            state_q    <= DEF_ERR1;
                            def_hready <= 1'b0;
                            def_hresp  <= HRESP_ERROR;
                            def_active <= 1'b1;
                        end else begin
                            state_q    <= DEF_IDLE;
                            def_hready <= 1'b1;
                            def_hresp  <= HRESP_OKAY;
                            def_active <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_slave_mux_n.sv
// N-port AHB-Lite slave response mux with an integrated default (ERROR) slave.
// Latency: zero added; data-phase outputs are combinational from the captured select.
// Backpressure: HREADY follows the selected slave (or default slave) and gates capture.
// Ports: HCLK, HRESETn; HSEL/HTRANS (address phase); HRDATA_S/HRESP_S/HREADYOUT_S
//        (per slave); HRDATA/HRESP/HREADY (to master); sel_err, err_cnt (status).
module ahb_slave_mux_n
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_SLAVES      = 4,
    parameter int ERR_ON_UNMAPPED = 1,
    parameter int CNT_W           = 8
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [1:0]                       HTRANS,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HRESP,
    output logic                             HREADY,
    output logic                             sel_err,
    output logic [CNT_W-1:0]                 err_cnt
);

    logic [NUM_SLAVES-1:0] dsel_q;
    logic                  sel_none;
    logic                  sel_multi;
    logic                  err_req;
    logic                  def_hready;
    logic                  def_hresp;
    logic                  def_active;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic                  s_resp;
    logic                  s_rdy;

    // Clearing the lowest set bit leaves something only if more than one bit is hot.
    assign sel_none  = (HSEL == '0);
    assign sel_multi = ((HSEL & (HSEL - NUM_SLAVES'(1))) != '0);
    assign err_req   = htrans_active(HTRANS) &&
                       (sel_multi || (sel_none && (ERR_ON_UNMAPPED != 0)));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_q  <= '0;
            sel_err <= 1'b0;
        end else if (HREADY) begin
            // A multi-hot select must never route more than one slave.
            dsel_q <= sel_multi ? '0 : HSEL;
            if (sel_multi) begin
                sel_err <= 1'b1;
            end
        end
    end

    ahb_default_slave #(
        .CNT_W (CNT_W)
    ) u_def (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HREADY     (HREADY),
        .err_req    (err_req),
        .def_hready (def_hready),
        .def_hresp  (def_hresp),
        .def_active (def_active),
        .err_cnt    (err_cnt)
    );

    // AND-OR mux: dsel_q is one-hot or zero, so OR-ing masked inputs is exact.
    always_comb begin
        s_rdata = '0;
        s_resp  = 1'b0;
        s_rdy   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_q[i]) begin
                s_rdata = s_rdata | HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                s_resp  = s_resp  | HRESP_S[i];
                s_rdy   = s_rdy   | HREADYOUT_S[i];
            end
        end
    end

    // dsel_q and def_active are mutually exclusive; neither set means idle OKAY.
    assign HRDATA = s_rdata;
    assign HRESP  = s_resp | (def_active & def_hresp);
    assign HREADY = def_active ? def_hready : ((dsel_q != '0) ? s_rdy : 1'b1);

endmodule

// File: tb/tb_ahb_slave_mux_n.sv
module tb_ahb_slave_mux_n;

    localparam int DW = 32;
    localparam int NS = 4;

    logic           HCLK;
    logic           HRESETn;
    logic [NS-1:0]  HSEL;
    logic [1:0]     HTRANS;
    logic [NS*DW-1:0] HRDATA_S;
    logic [NS-1:0]  HRESP_S;
    logic [NS-1:0]  HREADYOUT_S;

    logic [DW-1:0]  HRDATA_a, HRDATA_b;
    logic           HRESP_a, HRESP_b;
    logic           HREADY_a, HREADY_b;
    logic           sel_err_a, sel_err_b;
    logic [7:0]     err_cnt_a;
    logic [1:0]     err_cnt_b;

    // Default configuration.
    ahb_slave_mux_n #(.DATA_WIDTH(DW), .NUM_SLAVES(NS), .ERR_ON_UNMAPPED(1), .CNT_W(8)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
        .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S), .HREADYOUT_S(HREADYOUT_S),
        .HRDATA(HRDATA_a), .HRESP(HRESP_a), .HREADY(HREADY_a),
        .sel_err(sel_err_a), .err_cnt(err_cnt_a));

    // Unmapped gets zero-wait OKAY; narrow counter to exercise saturation.
    ahb_slave_mux_n #(.DATA_WIDTH(DW), .NUM_SLAVES(NS), .ERR_ON_UNMAPPED(0), .CNT_W(2)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
        .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S), .HREADYOUT_S(HREADYOUT_S),
        .HRDATA(HRDATA_b), .HRESP(HRESP_b), .HREADY(HREADY_b),
        .sel_err(sel_err_b), .err_cnt(err_cnt_b));

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          resp;
        logic          rdy;
        logic          serr;
        int            ecnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int tests = 0;
    int fails = 0;

    // Reference model, per configuration: who answers the current data phase.
    // owner = slave index or -1; err_left = ERROR cycles still to present (2,1,0).
    int  m_owner[2];
    int  m_err[2];
    int  m_ecnt[2];
    bit  m_serr[2];
    bit  m_rdy[2];
    int  err_unm[2] = '{1, 0};
    int  cnt_max[2] = '{255, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_err[d] = 0; m_ecnt[d] = 0; m_serr[d] = 0; m_rdy[d] = 1;
        end
    endtask

    // Applies the bus rules at a clock edge using the inputs present before it.
    task automatic model_edge(input int d);
        int cnt;
        int idx;
        cnt = 0; idx = -1;
        if (m_rdy[d]) begin
            for (int i = 0; i < NS; i++)
                if (HSEL[i]) begin cnt++; idx = i; end
            m_owner[d] = (cnt == 1) ? idx : -1;
            m_err[d]   = (HTRANS[1] && (cnt > 1 || (cnt == 0 && err_unm[d] != 0))) ? 2 : 0;
            if (cnt > 1) m_serr[d] = 1;
        end else if (m_err[d] == 2) begin
            m_err[d] = 1;
            if (m_ecnt[d] < cnt_max[d]) m_ecnt[d]++;
        end
    endtask

    function automatic exp_t model_out(input int d);
        exp_t e;
        e.rdata = '0; e.resp = 0; e.rdy = 1;
        if (m_err[d] == 2) begin
            e.rdy = 0; e.resp = 1;
        end else if (m_err[d] == 1) begin
            e.rdy = 1; e.resp = 1;
        end else if (m_owner[d] >= 0) begin
            e.rdata = HRDATA_S[m_owner[d]*DW +: DW];
            e.resp  = HRESP_S[m_owner[d]];
            e.rdy   = HREADYOUT_S[m_owner[d]];
        end
        e.serr = m_serr[d];
        e.ecnt = m_ecnt[d];
        return e;
    endfunction

    // One bus cycle: update model at the edge, drive new inputs, queue expectations.
    task automatic step(input logic [NS-1:0] hs, input logic [1:0] ht,
                        input logic [NS-1:0] ro, input bit rnd);
        exp_t ea, eb;
        int r;
        @(posedge HCLK);
        if (HRESETn) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        if (rnd) begin
            r = $urandom_range(0, 9);
            if (r < 5)      HSEL = NS'(1) << $urandom_range(0, NS-1);
            else if (r < 7) HSEL = '0;
            else if (r < 9) HSEL = (NS'(1) << $urandom_range(0, 1)) | (NS'(1) << $urandom_range(2, 3));
            else            HSEL = NS'($urandom);
            HTRANS   = ($urandom_range(0, 9) < 7) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
            HRDATA_S = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < NS; i++) begin
                HRESP_S[i]     = ($urandom_range(0, 9) == 0);
                HREADYOUT_S[i] = ($urandom_range(0, 3) != 0);
            end
        end else begin
            HSEL = hs; HTRANS = ht; HREADYOUT_S = ro; HRESP_S = '0;
            for (int i = 0; i < NS; i++) HRDATA_S[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
        end
        ea = model_out(0); m_rdy[0] = ea.rdy; q_a.push_back(ea);
        eb = model_out(1); m_rdy[1] = eb.rdy; q_b.push_back(eb);
    endtask

    // Monitor: compares the DUT against queued expectations on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("a_hrdata", HRDATA_a, e.rdata);
                chk("a_hresp", 32'(HRESP_a), 32'(e.resp));
                chk("a_hready", 32'(HREADY_a), 32'(e.rdy));
                chk("a_sel_err", 32'(sel_err_a), 32'(e.serr));
                chk("a_err_cnt", 32'(err_cnt_a), 32'(e.ecnt));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("b_hrdata", HRDATA_b, e.rdata);
                chk("b_hresp", 32'(HRESP_b), 32'(e.resp));
                chk("b_hready", 32'(HREADY_b), 32'(e.rdy));
                chk("b_sel_err", 32'(sel_err_b), 32'(e.serr));
                chk("b_err_cnt", 32'(err_cnt_b), 32'(e.ecnt));
            end
        end
    end

    initial begin
        int guard;
        HRESETn = 1'b0; HSEL = '0; HTRANS = 2'b00; HRDATA_S = '1;
        HRESP_S = '1; HREADYOUT_S = '0;
        model_reset();
        #2;
        chk("rst_hready", 32'(HREADY_a), 32'd1);
        chk("rst_hresp", 32'(HRESP_a), 32'd0);
        chk("rst_hrdata", HRDATA_a, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt_a), 32'd0);
        chk("rst_sel_err", 32'(sel_err_a), 32'd0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Idle bus after reset, then slave1 with a two-cycle stall and HSEL
        // wandering during the stall.
        step('0, 2'b00, '1, 0);
        step('0, 2'b00, '1, 0);
        step(4'b0010, 2'b10, 4'b1111, 0);
        step(4'b1000, 2'b10, 4'b1101, 0);
        step(4'b0100, 2'b10, 4'b1101, 0);
        step('0, 2'b00, 4'b1111, 0);
        // Unmapped, multi-hot, then back-to-back slave0 -> 3 -> unmapped -> 2.
        step('0, 2'b10, '1, 0);
        step('0, 2'b00, '1, 0);
        step('0, 2'b00, '1, 0);
        step(4'b0011, 2'b10, '1, 0);
        step('0, 2'b00, '1, 0);
        step('0, 2'b00, '1, 0);
        step(4'b0001, 2'b10, '1, 0);
        step(4'b1000, 2'b11, '1, 0);
        step('0, 2'b10, '1, 0);
        step(4'b0100, 2'b10, '1, 0);
        step('0, 2'b11, '1, 0);
        step(4'b0001, 2'b00, '1, 0);
        step('0, 2'b00, '1, 0);

        for (int n = 0; n < 1500; n++) step('0, 2'b00, '1, 1);

        // Saturate the 8-bit counter with a long run of unmapped NONSEQs.
        for (int n = 0; n < 600; n++) step('0, 2'b10, '1, 0);
        for (int n = 0; n < 200; n++) step('0, 2'b00, '1, 1);

        // Reset while the default slave sits in its first ERROR cycle.
        step('0, 2'b00, '1, 0);
        step('0, 2'b10, '1, 0);
        step('0, 2'b00, '1, 0);
        @(negedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_hready", 32'(HREADY_a), 32'd1);
        chk("mid_rst_hresp", 32'(HRESP_a), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt_a), 32'd0);
        chk("mid_rst_sel_err_b", 32'(sel_err_b), 32'd0);
        model_reset();
        HSEL = '0; HTRANS = 2'b00;
        @(negedge HCLK);
        HRESETn = 1'b1;
        step('0, 2'b00, '1, 0);
        step(4'b0100, 2'b10, '1, 0);
        for (int n = 0; n < 300; n++) step('0, 2'b00, '1, 1);

        guard = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && guard < 10) begin
            @(negedge HCLK);
            guard++;
        end
        #1;
        if (q_a.size() > 0 || q_b.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", q_a.size(), q_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
